// File: rtl/mmio_pkg.sv
// Shared constants for the game MMIO bridge: register offsets, button bit indices
// and the RAND LFSR seed/taps with its single-step helper.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;

  localparam int unsigned OFF_BTN_STATUS  = 0;
  localparam int unsigned OFF_BTN_EVENT   = 1;
  localparam int unsigned OFF_FRAME_COUNT = 2;
  localparam int unsigned OFF_FRAME_FLAG  = 3;
  localparam int unsigned OFF_SCORE       = 4;
  localparam int unsigned OFF_RAND        = 5;

  localparam int unsigned BTN_JUMP = 0;
  localparam int unsigned BTN_DUCK = 1;

  localparam logic [DATA_W-1:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois LFSR step
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return {1'b0, s[DATA_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one asynchronous button; emits a one-cycle rise pulse.
// A button held through reset is not reported as a press until it has been seen released.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             vld1_q, vld1_d;
  logic             vld2_q, vld2_d;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // Arm once a valid synchronized low has been observed
    armed_d = armed_q | (vld2_q & ~sync2_q);
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        rise_d  = sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      armed_q <= armed_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/mmio_bridge.sv
// Data-port bridge: RAM passthrough plus game I/O registers in the IO_BASE..0xFFF window.
// Optional macro MMIO_RAND_EN adds the RAND LFSR register; without it RAND reads 0.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FRAME_DIV       = 416667,
  parameter logic [11:0] IO_BASE         = 12'hFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proc_addr,
  input  logic        proc_wren,
  input  logic [31:0] proc_wdata,
  output logic [31:0] proc_rdata,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut,
  input  logic        btn_jump_raw,
  input  logic        btn_duck_raw,
  output logic [31:0] score_out
);

  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_DIV - 1);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] off;
  logic              is_io;
  logic              wr_io;
  logic              tick;
  logic [1:0]        btn_level;
  logic [1:0]        btn_rise;
  logic [DATA_W-1:0] rand_rdata;
  logic              unused_addr_hi;

  logic              sel_q, sel_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic [1:0]        btn_evt_q, btn_evt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              frame_flag_q, frame_flag_d;
  logic [DATA_W-1:0] score_q, score_d;

  assign addr           = proc_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^proc_addr[31:ADDR_W];
  assign is_io          = (addr >= IO_BASE);
  assign off            = addr - IO_BASE;
  assign wr_io          = proc_wren & is_io;

  assign ram_addr   = addr;
  assign ram_dataIn = proc_wdata;
  assign ram_wEn    = proc_wren & ~is_io;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump (
    .clock (clock),
    .reset (reset),
    .raw   (btn_jump_raw),
    .level (btn_level[BTN_JUMP]),
    .rise  (btn_rise[BTN_JUMP])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_duck (
    .clock (clock),
    .reset (reset),
    .raw   (btn_duck_raw),
    .level (btn_level[BTN_DUCK]),
    .rise  (btn_rise[BTN_DUCK])
  );

`ifdef MMIO_RAND_EN
  logic [DATA_W-1:0] lfsr_q, lfsr_d;

  // Free-running LFSR; a zero write reseeds with the default seed so it never locks up
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if (wr_io && off == ADDR_W'(OFF_RAND)) begin
      lfsr_d = (proc_wdata == '0) ? LFSR_SEED : proc_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign rand_rdata = lfsr_q;
`else
  assign rand_rdata = '0;
`endif

  // Register updates, frame divider and pre-write read mux
  always_comb begin
    tick         = (div_q == DIV_MAX);
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    frame_cnt_d  = frame_cnt_q + DATA_W'(tick);
    frame_flag_d = frame_flag_q;
    btn_evt_d    = btn_evt_q;
    score_d      = score_q;
    sel_d        = is_io;
    io_rdata_d   = '0;

    if (wr_io && off == ADDR_W'(OFF_BTN_EVENT))  btn_evt_d    = btn_evt_q & ~proc_wdata[1:0];
    if (wr_io && off == ADDR_W'(OFF_FRAME_FLAG)) frame_flag_d = frame_flag_q & ~proc_wdata[0];
    if (wr_io && off == ADDR_W'(OFF_SCORE))      score_d      = proc_wdata;

    // Set sources are applied last so they win over a same-cycle clear
    btn_evt_d    = btn_evt_d | btn_rise;
    frame_flag_d = frame_flag_d | tick;

    if (is_io) begin
      case (off)
        ADDR_W'(OFF_BTN_STATUS):  io_rdata_d = {30'b0, btn_level};
        ADDR_W'(OFF_BTN_EVENT):   io_rdata_d = {30'b0, btn_evt_q};
        ADDR_W'(OFF_FRAME_COUNT): io_rdata_d = frame_cnt_q;
        ADDR_W'(OFF_FRAME_FLAG):  io_rdata_d = {31'b0, frame_flag_q};
        ADDR_W'(OFF_SCORE):       io_rdata_d = score_q;
        ADDR_W'(OFF_RAND):        io_rdata_d = rand_rdata;
        default:                  io_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q        <= 1'b0;
      io_rdata_q   <= '0;
      btn_evt_q    <= '0;
      div_q        <= '0;
      frame_cnt_q  <= '0;
      frame_flag_q <= 1'b0;
      score_q      <= '0;
    end else begin
      sel_q        <= sel_d;
      io_rdata_q   <= io_rdata_d;
      btn_evt_q    <= btn_evt_d;
      div_q        <= div_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_flag_q <= frame_flag_d;
      score_q      <= score_d;
    end
  end

  assign proc_rdata = sel_q ? io_rdata_q : ram_dataOut;
  assign score_out  = score_q;

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the processor data-memory port and the data RAM in the top-level wrapper.
- Decodes the 12-bit data address. Addresses IO_BASE..0xFFF go to game I/O registers; all other addresses pass through to RAM.
- I/O registers cover debounced jump/duck buttons, a sticky press-event latch, a ~60 Hz frame tick/counter, and a score register driven out to the display logic.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a button level is accepted (10 ms at 25 MHz).
- FRAME_DIV, 416667: clock cycles per frame tick (60 Hz at 25 MHz).
- IO_BASE, 12'hFF0: first I/O address; the I/O window is IO_BASE..12'hFFF.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- proc_addr  in  32  processor data address; only [11:0] decoded
- proc_wren  in  1  processor store strobe
- proc_wdata  in  32  processor store data
- proc_rdata  out  32  load data returned to processor
- ram_wEn  out  1  RAM write enable
- ram_addr  out  12  RAM address
- ram_dataIn  out  32  RAM write data
- ram_dataOut  in  32  RAM read data (RAM read is registered, 1 cycle)
- btn_jump_raw  in  1  asynchronous jump button
- btn_duck_raw  in  1  asynchronous duck button
- score_out  out  32  current SCORE register

Behaviour:
- Decode: is_io = (proc_addr[11:0] >= IO_BASE).
- RAM path, combinational:
  - ram_addr = proc_addr[11:0] and ram_dataIn = proc_wdata always.
  - ram_wEn = proc_wren & ~is_io, so the I/O window is never written in RAM.
- Read latency is 1 cycle for both paths:
  - The I/O read value and is_io are registered (sel_q).
  - proc_rdata = sel_q ? io_rdata_q : ram_dataOut.
- I/O register map, as offsets from IO_BASE:
  - 0 BTN_STATUS, RO: bit0 = debounced jump, bit1 = debounced duck.
  - 1 BTN_EVENT, W1C: bit0 is set on a debounced jump rising edge; bit1 likewise for duck. A write clears the bits where proc_wdata is 1.
  - 2 FRAME_COUNT, RO: 32-bit count of frame ticks; wraps 0xFFFFFFFF -> 0.
  - 3 FRAME_FLAG, W1C: bit0 is set on every frame tick.
  - 4 SCORE, RW: full 32 bits; drives score_out.
  - 5 RAND: see Optional Feature.
  - 6..15: read as 0; writes ignored.
- Simultaneous set and W1C clear in the same cycle: set wins, so the bit stays 1.
- Debounce, per button:
  - 2-FF synchronizer, then a counter.
  - While the synchronized value differs from the accepted level, the counter increments. When it reaches DEBOUNCE_CYCLES-1, the level updates and the counter clears.
  - Any cycle where they are equal clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Rising-edge pulse = level_new & ~level_old, one cycle wide.
- Frame divider: counts 0..FRAME_DIV-1. At terminal count it emits a 1-cycle tick and returns to 0.
- Reset, synchronous and takes effect even mid-operation:
  - All registers, counters, synchronizers and sel_q go to 0.
  - proc_rdata = ram_dataOut on the cycle after reset.
  - score_out = 0.
  - BTN_STATUS = 0 regardless of button state; a button held through reset produces no event until it is released and pressed again.
- A load and a store to the same I/O register in the same cycle returns the pre-write value.

Optional Feature:
- Macro: MMIO_RAND_EN.
- Defined:
  - RAND (offset 5) is a 32-bit Galois LFSR, taps 0x80200003, stepping every cycle.
  - Reset seed is 0xACE10001.
  - Writing any value reseeds with proc_wdata; a write of 0 reseeds with 0xACE10001 instead.
- Undefined: RAND reads 0, writes are ignored, and no LFSR logic is synthesized.

Decomposition:
- Package mmio_pkg holds:
  - the register offset localparams (OFF_BTN_STATUS=0 … OFF_RAND=5);
  - the bit indices BTN_JUMP=0, BTN_DUCK=1;
  - the LFSR seed and tap constants.
- Sub-module button_debouncer (params DEBOUNCE_CYCLES; ports clock, reset, raw, level, rise), instantiated twice.
- Decode, registers and divider stay in mmio_bridge.

Test Plan:
1. RAM passthrough: store 0x1234 to addr 0x010, then load 0x010 → ram_wEn=1 on the store; proc_rdata=0x1234 one cycle after the load. Store to 0xFF4 → ram_wEn=0.
2. Debounce, with DEBOUNCE_CYCLES=8 in the bench:
   - Jump high for 5 cycles → BTN_STATUS=0, BTN_EVENT=0.
   - Jump held high 20 cycles → BTN_STATUS bit0=1 at cycle 8+2 sync, and BTN_EVENT bit0=1.
3. W1C race: write 0x1 to BTN_EVENT on the same cycle as a new jump rise → BTN_EVENT bit0 stays 1. A separate write 0x1 later → reads 0.
4. Frame tick, with FRAME_DIV=4:
   - After 40 cycles, FRAME_COUNT=10 and FRAME_FLAG=1.
   - Write 1 to FRAME_FLAG → 0 until the next tick.
   - Preload via force at 0xFFFFFFFF → next tick reads 0.
5. Reset mid-operation: SCORE=0x55, event pending, button held; assert reset 1 cycle → score_out=0, BTN_EVENT=0, BTN_STATUS=0. No event while held after reset; release and re-press → event.
6. MMIO_RAND_EN:
   - Defined: first read after reset is 1 LFSR step past 0xACE10001; consecutive reads differ; write 0 → sequence restarts from the seed.
   - Undefined: RAND reads 0.
